// File: rtl/fft_stage_sequencer_if.sv
// Control/status bundle between the FFT frame sequencer and its user.
// The master side issues enable/start and observes the decoded frame timing.
interface fft_stage_sequencer_if #(
    parameter int N_LOG2 = 7
) ();
    logic                  en;
    logic                  start;
    logic                  busy;
    logic                  in_take;
    logic [2*N_LOG2-1:0]   sel;
    logic                  out_valid;
    logic                  frame_done;
    logic                  start_drop;

    modport master (
        output en, start,
        input  busy, in_take, sel, out_valid, frame_done, start_drop
    );

    modport slave (
        input  en, start,
        output busy, in_take, sel, out_valid, frame_done, start_drop
    );
endinterface

// File: rtl/fft_stage_sequencer.sv
// Frame-level controller for a radix-2 single-delay-feedback FFT pipeline.
// One frame counter drives every stage's commutator select, the input-take
// strobe, the output-valid window and the end-of-frame handshakes.
module fft_stage_sequencer #(
    parameter int N_LOG2 = 7,
    parameter int CW     = N_LOG2 + 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    fft_stage_sequencer_if.slave  bus
);
    localparam int            N      = 1 << N_LOG2;
    localparam logic [CW-1:0] LAST   = CW'(2 * N);
    localparam logic [CW-1:0] IN_END = CW'(N);
    // Last stage window starts at N; its output register adds one cycle.
    localparam logic [CW-1:0] OV_LO  = CW'(N + 1);
    localparam logic [CW-1:0] OV_HI  = CW'(2 * N);

    logic                 busy;
    logic [CW-1:0]        count;
    logic                 at_last;
    logic [2*N_LOG2-1:0]  sel_v;

    assign at_last = (count == LAST);

    // Frame state: idle/running flag and the single frame counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy  <= 1'b0;
            count <= '0;
        end else if (bus.en) begin
            if (!busy) begin
                if (bus.start) begin
                    busy  <= 1'b1;
                    count <= '0;
                end
            end else if (at_last) begin
                // Held start at the last count chains the next frame with no bubble.
                busy  <= bus.start;
                count <= '0;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

    // Frame-level decodes of the counter and handshake inputs.
    always_comb begin
        bus.busy       = busy;
        bus.in_take    = busy && (count < IN_END);
        bus.out_valid  = busy && (count >= OV_LO) && (count <= OV_HI);
        bus.frame_done = bus.en && busy && at_last;
        bus.start_drop = bus.en && busy && bus.start && !at_last;
        bus.sel        = sel_v;
    end

    // Per-stage commutator select: 2 outside the stage window, otherwise the
    // offset bit whose period is twice the stage delay line length.
    for (genvar s = 0; s < N_LOG2; s++) begin : g_sel
        localparam int            H         = N >> (s + 1);
        localparam logic [CW-1:0] W_LO      = CW'(N + 1 - H);
        localparam logic [CW-1:0] W_HI      = CW'(N + 1 - H + N);
        localparam logic [CW-1:0] STAGE_BIT = CW'(1) << (N_LOG2 - 1 - s);

        logic          in_win;
        logic [CW-1:0] offset;
        logic          phase;

        assign in_win = busy && (count >= W_LO) && (count < W_HI);
        assign offset = count - W_LO;
        assign phase  = |(offset & STAGE_BIT);
        assign sel_v[2*s +: 2] = in_win ? {1'b0, phase} : 2'd2;
    end

    count_in_range : assert property (@(posedge clk) disable iff (!rst_n) count <= LAST);

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Scoreboard bench for fft_stage_sequencer: the driver computes expected
// outputs from a frame-position reference model and queues them; a monitor
// compares the DUT against the queue every cycle.
module tb_fft_stage_sequencer;
    localparam int NL = 7;
    localparam int N  = 1 << NL;

    typedef struct packed {
        logic            busy;
        logic            in_take;
        logic            out_valid;
        logic            frame_done;
        logic            start_drop;
        logic [2*NL-1:0] sel;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    fft_stage_sequencer_if #(.N_LOG2(NL)) bus ();

    fft_stage_sequencer #(.N_LOG2(NL), .CW(NL + 2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model: whether a frame is active and the position in it.
    bit   m_active = 1'b0;
    int   m_pos    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t expected(input bit en, input bit st);
        exp_t e;
        int   h, w, v;
        e.busy       = m_active;
        e.in_take    = m_active && (m_pos < N);
        e.out_valid  = m_active && (m_pos > N) && (m_pos <= 2 * N);
        e.frame_done = en && m_active && (m_pos == 2 * N);
        e.start_drop = en && st && m_active && (m_pos != 2 * N);
        e.sel        = '0;
        for (int s = 0; s < NL; s++) begin
            h = N >> (s + 1);
            w = N + 1 - h;
            if (m_active && m_pos >= w && m_pos < w + N)
                v = ((m_pos - w) / h) % 2;
            else
                v = 2;
            e.sel[2*s +: 2] = 2'(v);
        end
        return e;
    endfunction

    task automatic advance(input bit st);
        if (!m_active) begin
            if (st) begin
                m_active = 1'b1;
                m_pos    = 0;
            end
        end else if (m_pos == 2 * N) begin
            m_active = st;
            m_pos    = 0;
        end else begin
            m_pos++;
        end
    endtask

    task automatic step(input bit rst, input bit en, input bit st);
        @(posedge clk);
        #1;
        rst_n     = !rst;
        bus.en    = en;
        bus.start = st;
        if (rst) begin
            m_active = 1'b0;
            m_pos    = 0;
        end
        sb.push_back(expected(en, st));
        if (!rst && en) advance(st);
    endtask

    task automatic run_until_pos(input int p);
        int guard = 0;
        while (!(m_active && m_pos == p) && guard < 1000) begin
            step(1'b0, 1'b1, 1'b0);
            guard++;
        end
        checks++;
        if (guard >= 1000) begin
            failures++;
            $display("FAIL run_until_pos actual=timeout expected=pos %0d", p);
        end
    endtask

    // Monitor: compares every presented cycle against the queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("busy",       32'(bus.busy),       32'(e.busy));
                check("in_take",    32'(bus.in_take),    32'(e.in_take));
                check("out_valid",  32'(bus.out_valid),  32'(e.out_valid));
                check("frame_done", 32'(bus.frame_done), 32'(e.frame_done));
                check("start_drop", 32'(bus.start_drop), 32'(e.start_drop));
                check("sel",        32'(bus.sel),        32'(e.sel));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.en    = 1'b0;
        bus.start = 1'b0;

        // Reset, then idle with no start.
        repeat (3) step(1'b1, 1'b0, 1'b0);
        repeat (50) step(1'b0, 1'b1, 1'b0);

        // Single frame with start pulses at positions 10 and 200.
        step(1'b0, 1'b1, 1'b1);
        repeat (300) step(1'b0, 1'b1, m_active && (m_pos == 10 || m_pos == 200));

        // Back-to-back: start held across the last count.
        step(1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 600; i++) step(1'b0, 1'b1, (i >= 250 && i < 262));

        // Stall at position 120 with start asserted during the stall.
        step(1'b0, 1'b1, 1'b1);
        run_until_pos(120);
        repeat (5) step(1'b0, 1'b0, 1'b1);
        repeat (200) step(1'b0, 1'b1, 1'b0);

        // Reset mid-frame with start held, then restart only with en high.
        step(1'b0, 1'b1, 1'b1);
        run_until_pos(150);
        repeat (3) step(1'b1, 1'b1, 1'b1);
        repeat (2) step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        repeat (300) step(1'b0, 1'b1, 1'b0);

        // Randomized enable, start and occasional reset.
        for (int i = 0; i < 3000; i++)
            step(($urandom_range(0, 1999) == 0), ($urandom_range(0, 9) != 0),
                 ($urandom_range(0, 49) == 0));

        repeat (3) @(posedge clk);
        check("scoreboard_drain", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fft_stage_sequencer.md
Name: fft_stage_sequencer

Overview:
- Frame-level controller for the 128-point radix-2 single-delay-feedback FFT pipeline.
- Accepts a start pulse, runs one frame counter, and drives every stage's commutator select from that single counter.
- Also drives the input-take strobe, the output-valid window and end-of-frame/back-to-back handshakes.
- Replaces the per-stage free-running select controllers with one stallable, resettable sequencer.

Parameters:
- N_LOG2, 7, log2 of FFT length; number of butterfly stages S = N_LOG2; N = 2**N_LOG2.
- CW, N_LOG2+2, frame counter width; must hold LAST = 2N (256 at default).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  global pipeline enable; low freezes the sequencer.
- start  in  1  frame request; single-cycle or held.
- busy  out  1  frame in progress.
- in_take  out  1  datapath samples the input this cycle.
- sel  out  2*N_LOG2  packed stage selects; stage s uses bits [2s+1:2s].
- out_valid  out  1  FFT output sample valid.
- frame_done  out  1  single-cycle end-of-frame pulse.
- start_drop  out  1  single-cycle pulse: start was ignored.

Behaviour:
- State: busy flag plus count[CW-1:0]. All outputs are combinational decodes of these registers and of en/start. There are no other state elements.
- Reset (async, rst_n=0): busy=0, count=0. Therefore sel is all 2'd2, and in_take, out_valid, frame_done and start_drop are all 0.
- Reset release is synchronous to clk with no extra latency. Reset mid-frame aborts the frame immediately; the next frame needs a new start.
- Constants:
  - H_s = N >> (s+1) (64, 32, ..., 1).
  - W_s = N + 1 - H_s (stage window start: 65, 97, 113, 121, 125, 127, 128).
  - LAST = 2N.
- Idle (busy=0):
  - en=1 and start=1: next cycle busy=1, count=0.
  - Otherwise hold.
- Running (busy=1, en=1):
  - count < LAST: count <= count+1. If start=1, start_drop=1 and start has no other effect.
  - count == LAST: frame_done=1.
    - start=1: count <= 0 and busy stays 1 (back-to-back frame, zero bubble). start_drop=0.
    - start=0: busy <= 0, count <= 0.
- en=0: count and busy hold; all decoded outputs keep their values. frame_done=0, start_drop=0, and start is ignored (not dropped, not latched).
- in_take = busy && count < N. Counts 0..N-1 are input samples 0..N-1.
- sel for stage s:
  - Outside the window (busy=0, or count < W_s, or count >= W_s+N): 2'd2, i.e. flush/idle path.
  - Inside the window: ((count - W_s) >> (N_LOG2-1-s)) & 1. This gives 0 for the first H_s cycles and 1 for the next H_s, alternating, for N cycles total.
  - Subtraction is done in CW bits; it cannot wrap inside the window.
- out_valid = busy && W_last+1 <= count <= W_last+N, where W_last = W_{S-1}. Default window is 129..256; the last-stage output register adds 1 cycle.
- Latency: start accepted at cycle t. First input taken at t+1; first out_valid at t+1+W_last+1; frame_done at t+1+LAST.
- Width rule: count never exceeds LAST. Reaching LAST+1 is a design error and must be caught by an assertion.

Test Plan:
- Reset then idle, start=0 for 50 cycles -> busy=0, sel=all 2'd2, in_take=out_valid=frame_done=0.
- Single start, en=1, sample stage-2 sel by count:
  - count 112 -> 2; 113..128 -> 0; 129..144 -> 1; 145..160 -> 0; 225..240 -> 1; 241 -> 2.
  - Stage 0: 65..128 -> 0, 129..192 -> 1.
  - Stage 6 toggles every cycle over 128..255.
  - in_take high for exactly 128 cycles; out_valid over counts 129..256; frame_done at 256.
- Back-to-back: hold start=1 through count 256 -> frame_done=1, count returns to 0 with busy=1, and in_take is high the next cycle (no gap).
- Start pulses at count 10 and 200 -> start_drop=1 on each, and frame timing is unchanged.
- Stall: en=0 for 5 cycles at count 120 -> count, sel (stage 2 = 0), in_take and out_valid frozen. Resume completes the frame 5 cycles later than unstalled. Start during stall is ignored, with no start_drop.
- rst_n low at count 150, start held high -> immediate sel=2'd2 and busy=0. After release, a new frame begins only on start sampled with en=1; count restarts at 0.
